// File: rtl/gray_pkg.sv
//------------------------------------------------------------------------------
// gray_pkg
// Shared definitions for the Gray up/down counter: direction encodings and
// width-generic binary<->Gray helper functions (operate on a MAX_WIDTH vector;
// callers zero-extend narrower values and slice the result).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package gray_pkg;

  localparam int   MAX_WIDTH = 16;
  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;

  // Binary to Gray: each Gray bit is the XOR of adjacent binary bits.
  function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
    logic [MAX_WIDTH-1:0] b;
    b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
    for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bin2gray_conv.sv
//------------------------------------------------------------------------------
// bin2gray_conv
// Purely combinational binary to Gray code converter.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bin2gray_conv #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  // Adjacent-bit XOR; the MSB passes straight through.
  assign gray = bin ^ (bin >> 1);

endmodule

`default_nettype wire

// File: rtl/gray_updown_counter.sv
//------------------------------------------------------------------------------
// gray_updown_counter
// Parametrised Moore up/down counter holding a binary count, presenting it in
// both binary and Gray form, with count enable, synchronous parallel load,
// min/max flags and a one-cycle wrap pulse. All outputs decode registered
// state only.
// Build option: define GRAY_COUNTER_SATURATE_EN to saturate at the ends of the
// range instead of wrapping (wrap output then stays 0).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module gray_updown_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin_q,
  output logic [WIDTH-1:0] gray_q,
  output logic             at_max,
  output logic             at_min,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] C_ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] C_ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] C_ZERO     = {WIDTH{1'b0}};

  logic [WIDTH-1:0] cnt;
  logic             wrap_r;
  logic [WIDTH-1:0] cnt_nxt;
  logic             wrap_nxt;
  logic             is_max;
  logic             is_min;

  assign is_max = (cnt == C_ALL_ONES);
  assign is_min = (cnt == C_ZERO);

  // Next count for an enabled step; hold and a cleared wrap otherwise.
  always_comb begin
    cnt_nxt  = cnt;
    wrap_nxt = 1'b0;
    if (en) begin
      if (up == DIR_UP) begin
`ifdef GRAY_COUNTER_SATURATE_EN
        if (!is_max) cnt_nxt = cnt + C_ONE;
`else
        cnt_nxt  = cnt + C_ONE;
        wrap_nxt = is_max;
`endif
      end else begin
`ifdef GRAY_COUNTER_SATURATE_EN
        if (!is_min) cnt_nxt = cnt - C_ONE;
`else
        cnt_nxt  = cnt - C_ONE;
        wrap_nxt = is_min;
`endif
      end
    end
  end

  // State update with priority rst > load > step/hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= C_ZERO;
      wrap_r <= 1'b0;
    end else if (load) begin
      cnt    <= load_val;
      wrap_r <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      wrap_r <= wrap_nxt;
    end
  end

  bin2gray_conv #(
    .WIDTH (WIDTH)
  ) u_bin2gray (
    .bin  (cnt),
    .gray (gray_q)
  );

  assign bin_q  = cnt;
  assign at_max = is_max;
  assign at_min = is_min;
  assign wrap   = wrap_r;

endmodule

`default_nettype wire

// File: tb/tb_gray_updown_counter.sv
//------------------------------------------------------------------------------
// tb_gray_updown_counter
// Self-checking bench for gray_updown_counter at WIDTH = 3, 4 and 8.
// Honours GRAY_COUNTER_SATURATE_EN when defined.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_gray_updown_counter;
  import gray_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH = 3 instance
  logic       rst3 = 1'b1, en3 = 1'b0, up3 = 1'b0, load3 = 1'b0;
  logic [2:0] lv3 = '0, bin3, gray3;
  logic       max3, min3, wrap3;
  // WIDTH = 4 instance
  logic       rst4 = 1'b1, en4 = 1'b0, up4 = 1'b0, load4 = 1'b0;
  logic [3:0] lv4 = '0, bin4, gray4;
  logic       max4, min4, wrap4;
  // WIDTH = 8 instance
  logic       rst8 = 1'b1, en8 = 1'b0, up8 = 1'b0, load8 = 1'b0;
  logic [7:0] lv8 = '0, bin8, gray8;
  logic       max8, min8, wrap8;

  gray_updown_counter #(.WIDTH(3)) u_dut3 (
    .clk(clk), .rst(rst3), .en(en3), .up(up3), .load(load3), .load_val(lv3),
    .bin_q(bin3), .gray_q(gray3), .at_max(max3), .at_min(min3), .wrap(wrap3));
  gray_updown_counter #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst4), .en(en4), .up(up4), .load(load4), .load_val(lv4),
    .bin_q(bin4), .gray_q(gray4), .at_max(max4), .at_min(min4), .wrap(wrap4));
  gray_updown_counter #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst8), .en(en8), .up(up8), .load(load8), .load_val(lv8),
    .bin_q(bin8), .gray_q(gray8), .at_max(max8), .at_min(min8), .wrap(wrap8));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // Advance one rising edge, then settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifdef GRAY_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic [2:0] g3_tab [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

  initial begin
    logic [2:0] e3;
    logic       ew;
    logic [7:0] mb, prev_g, lvr;
    logic       mw, e, u, l;
    logic [15:0] gb;

    #2;
    tick(); tick();
    rst3 = 1'b0; rst4 = 1'b0; rst8 = 1'b0;
    // Reset state
    check("rst_bin3",  bin3,  0);
    check("rst_gray3", gray3, 0);
    check("rst_min3",  min3,  1);
    check("rst_max3",  max3,  0);
    check("rst_wrap3", wrap3, 0);
    check("rst_bin8",  bin8,  0);

    // Reset then up-count
    rst3 = 1'b1; tick(); tick(); rst3 = 1'b0;
    en3 = 1'b1; up3 = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      e3 = SAT ? ((k > 7) ? 3'd7 : 3'(k)) : 3'(k % 8);
      ew = !SAT && (k == 8);
      check($sformatf("up_bin_%0d", k),  bin3,  e3);
      check($sformatf("up_gray_%0d", k), gray3, g3_tab[e3]);
      check($sformatf("up_wrap_%0d", k), wrap3, ew);
      check($sformatf("up_max_%0d", k),  max3,  (e3 == 3'd7));
    end
    en3 = 1'b0;

    // Down-count wrap
    rst3 = 1'b1; tick(); rst3 = 1'b0;
    check("dn_min0", min3, 1);
    en3 = 1'b1; up3 = 1'b0;
    tick();
    check("dn_bin1",  bin3,  SAT ? 0 : 7);
    check("dn_wrap1", wrap3, SAT ? 0 : 1);
    check("dn_max1",  max3,  SAT ? 0 : 1);
    tick();
    check("dn_bin2",  bin3,  SAT ? 0 : 6);
    check("dn_wrap2", wrap3, 0);
    en3 = 1'b0;

    // Load takes priority over enable
    load4 = 1'b1; lv4 = 4'd9; en4 = 1'b1; up4 = 1'b1;
    tick();
    load4 = 1'b0;
    check("ld_bin",  bin4,  9);
    check("ld_gray", gray4, 4'b1101);
    check("ld_wrap", wrap4, 0);
    tick();
    en4 = 1'b0;
    check("ld_inc_bin",  bin4,  10);
    check("ld_inc_gray", gray4, 4'b1111);

    // Hold, then reset overrides load mid-count
    rst3 = 1'b1; tick(); rst3 = 1'b0;
    en3 = 1'b1; up3 = 1'b1;
    repeat (5) tick();
    check("cnt5", bin3, 5);
    en3 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("hold_bin_%0d", k),  bin3,  5);
      check($sformatf("hold_wrap_%0d", k), wrap3, 0);
    end
    rst3 = 1'b1; load3 = 1'b1; lv3 = 3'd3; en3 = 1'b1;
    tick();
    rst3 = 1'b0; load3 = 1'b0; en3 = 1'b0;
    check("rst_ovr_bin", bin3, 0);
    check("rst_ovr_min", min3, 1);

`ifdef GRAY_COUNTER_SATURATE_EN
    // Saturation at both ends
    load3 = 1'b1; lv3 = 3'd7; tick(); load3 = 1'b0;
    en3 = 1'b1; up3 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("sat_hi_bin_%0d", k),  bin3,  7);
      check($sformatf("sat_hi_wrap_%0d", k), wrap3, 0);
    end
    en3 = 1'b0;
    load3 = 1'b1; lv3 = 3'd0; tick(); load3 = 1'b0;
    en3 = 1'b1; up3 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      check($sformatf("sat_lo_bin_%0d", k),  bin3,  0);
      check($sformatf("sat_lo_wrap_%0d", k), wrap3, 0);
    end
    en3 = 1'b0;
`endif

    // Random direction/enable with occasional loads, WIDTH = 8
    mb = 8'd0; mw = 1'b0; prev_g = gray8;
    for (int c = 0; c < 2000; c++) begin
      e = 1'($urandom_range(0, 3) != 0);
      u = 1'($urandom_range(0, 1));
      l = 1'($urandom_range(0, 31) == 0);
      case ($urandom_range(0, 4))
        0: lvr = 8'd0;
        1: lvr = 8'd1;
        2: lvr = 8'd254;
        3: lvr = 8'd255;
        default: lvr = 8'($urandom_range(0, 255));
      endcase
      en8 = e; up8 = u; load8 = l; lv8 = lvr;
      if (l) begin
        mb = lvr; mw = 1'b0;
      end else if (e && u) begin
        if (SAT) begin
          mw = 1'b0;
          if (mb != 8'd255) mb = mb + 8'd1;
        end else begin
          mw = (mb == 8'd255); mb = mb + 8'd1;
        end
      end else if (e) begin
        if (SAT) begin
          mw = 1'b0;
          if (mb != 8'd0) mb = mb - 8'd1;
        end else begin
          mw = (mb == 8'd0); mb = mb - 8'd1;
        end
      end else begin
        mw = 1'b0;
      end
      tick();
      gb = gray2bin({8'd0, gray8});
      check("rnd_bin",  bin8,  mb);
      check("rnd_wrap", wrap8, mw);
      check("rnd_max",  max8,  (mb == 8'd255));
      check("rnd_min",  min8,  (mb == 8'd0));
      check("rnd_g2b",  gb[7:0], bin8);
      if (!l) check("rnd_hamming_le1", ($countones(prev_g ^ gray8) <= 1), 1);
      prev_g = gray8;
    end
    en8 = 1'b0; load8 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
